sm_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction ROM. It holds the program counter and drives the ROM byte address. It captures the combinational ROM read data into an IF/ID pipeline register and presents it to decode through a valid/ready handshake. Branch and jump redirects from later stages flush the register and reload the PC.

---
 rtl/sm_fetch.sv | 78 +++++++
 tb/tb_sm_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_fetch.sv
// sm_fetch: instruction fetch stage holding the pc and an IF/ID register with valid/ready handoff
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   imAddr       byte address to the combinational ROM (current pc)
//   imData       ROM word for imAddr, captured on the same edge
//   fetch_en     1 = issue fetches, 0 = stop issuing and hold pc
//   redirect     take redirect_pc this cycle; flushes the IF/ID register
//   redirect_pc  redirect target, word aligned internally
//   id_ready     decode accepts if_instr this cycle
//   if_valid     IF/ID register holds a valid instruction
//   if_instr     fetched word, NOP_INSTR when the slot is empty
//   if_pc        byte address of if_instr
//   if_pc4       if_pc + 4 (mod 2^32)
//   fetch_cnt    count of instructions handed to decode
module sm_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imAddr,
  input  logic [31:0] imData,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] fetch_cnt
);
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_cnt;
  logic        w_accept;
  logic        w_slot_free;
  assign w_accept    = r_valid && id_ready;
  assign w_slot_free = !r_valid || id_ready;
  // A redirect still counts an instruction decode consumed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end
  // Stall (valid && !ready) falls through every branch, so everything holds
  // and the pc stays put, keeping the ROM address stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_if_pc <= '0;
    end else if (redirect) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (w_slot_free && fetch_en) begin
      r_instr <= imData;
      r_if_pc <= r_pc;
      r_valid <= 1'b1;
      r_pc    <= r_pc + 32'd4;
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end
  assign imAddr    = r_pc;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc + 32'd4;
  assign fetch_cnt = r_cnt;
endmodule

// File: tb/tb_sm_fetch.sv
// tb_sm_fetch: directed and randomized checks of sm_fetch against a reference model
module tb_sm_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] fetch_cnt;
  logic [31:0] rom [64];
  int tests = 0;
  int fails = 0;
  logic        m_valid;
  logic [31:0] m_instr, m_ifpc, m_pc, m_cnt;
  always #5 clk = ~clk;
  assign im_data = rom[im_addr[7:2]];
  sm_fetch dut (
    .clk(clk), .rst_n(rst_n), .imAddr(im_addr), .imData(im_data),
    .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc4(if_pc4), .fetch_cnt(fetch_cnt)
  );
  task automatic fill_rom_seq();
    for (int i = 0; i < 64; i++) rom[i] = 32'h100 + i;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    m_valid = 1'b0; m_instr = NOP; m_ifpc = 0; m_pc = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // Reference: the spec's per-edge priority rules applied to the current inputs.
  task automatic tick();
    logic take, free;
    take = m_valid && id_ready;
    free = !m_valid || id_ready;
    if (take) m_cnt = m_cnt + 1;
    if (redirect) begin
      m_pc = redirect_pc & ~32'd3; m_valid = 0; m_instr = NOP;
    end else if (free && fetch_en) begin
      m_instr = rom[m_pc[7:2]]; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 4;
    end else if (free) begin
      m_valid = 0; m_instr = NOP;
    end
    @(negedge clk);
  endtask
  task automatic step(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 0 || im_addr !== 0 || fetch_cnt !== 0) begin
      fails++;
      $display("FAIL reset: valid=%b instr=%h pc=%h imaddr=%h cnt=%0d, want 0/%h/0/0/0", if_valid, if_instr, if_pc, im_addr, fetch_cnt, NOP);
    end
  endtask
  task automatic test_free_run();
    do_reset();
    step(1);
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 0 || if_instr !== 32'h100) begin
      fails++;
      $display("FAIL free_run_c1: valid=%b pc=%h instr=%h, want 1/0/100", if_valid, if_pc, if_instr);
    end
    step(3);
    tests++;
    if (if_pc !== 12 || if_instr !== 32'h103 || fetch_cnt !== 3 || if_pc4 !== 16) begin
      fails++;
      $display("FAIL free_run_c4: pc=%h instr=%h cnt=%0d pc4=%h, want c/103/3/10", if_pc, if_instr, fetch_cnt, if_pc4);
    end
  endtask
  task automatic test_stall();
    do_reset();
    step(3);
    id_ready = 1'b0;
    step(3);
    tests++;
    if (if_pc !== 8 || if_instr !== 32'h102 || im_addr !== 12 || fetch_cnt !== 2 || if_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_hold: pc=%h instr=%h imaddr=%h cnt=%0d valid=%b, want 8/102/c/2/1", if_pc, if_instr, im_addr, fetch_cnt, if_valid);
    end
    id_ready = 1'b1;
    step(1);
    tests++;
    if (if_pc !== 12 || fetch_cnt !== 3) begin
      fails++;
      $display("FAIL stall_release: pc=%h cnt=%0d, want c/3", if_pc, fetch_cnt);
    end
  endtask
  task automatic test_redirect();
    do_reset();
    step(2);
    redirect = 1'b1;
    redirect_pc = 32'h2E;
    step(1);
    redirect = 1'b0;
    tests++;
    if (if_valid !== 1'b0 || if_instr !== NOP || im_addr !== 32'h2C || fetch_cnt !== 2) begin
      fails++;
      $display("FAIL redirect_flush: valid=%b instr=%h imaddr=%h cnt=%0d, want 0/13/2c/2", if_valid, if_instr, im_addr, fetch_cnt);
    end
    step(1);
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h2C || if_instr !== 32'h10B) begin
      fails++;
      $display("FAIL redirect_target: valid=%b pc=%h instr=%h, want 1/2c/10b", if_valid, if_pc, if_instr);
    end
  endtask
  task automatic test_redirect_stall();
    do_reset();
    step(1);
    id_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step(1);
    tests++;
    if (if_valid !== 1'b0 || fetch_cnt !== 0 || im_addr !== 32'h40) begin
      fails++;
      $display("FAIL redirect_stall: valid=%b cnt=%0d imaddr=%h, want 0/0/40", if_valid, fetch_cnt, im_addr);
    end
    redirect = 1'b0;
    id_ready = 1'b1;
    step(1);
    redirect = 1'b1;
    redirect_pc = 32'h8;
    step(1);
    redirect = 1'b0;
    tests++;
    if (if_valid !== 1'b0 || fetch_cnt !== 1 || im_addr !== 32'h8) begin
      fails++;
      $display("FAIL redirect_accept: valid=%b cnt=%0d imaddr=%h, want 0/1/8", if_valid, fetch_cnt, im_addr);
    end
  endtask
  task automatic test_fetch_en();
    do_reset();
    step(4);
    fetch_en = 1'b0;
    step(2);
    tests++;
    if (if_valid !== 1'b0 || if_instr !== NOP || im_addr !== 16 || fetch_cnt !== 4) begin
      fails++;
      $display("FAIL fetch_dis: valid=%b instr=%h imaddr=%h cnt=%0d, want 0/13/10/4", if_valid, if_instr, im_addr, fetch_cnt);
    end
    fetch_en = 1'b1;
    step(1);
    tests++;
    if (if_valid !== 1'b1 || if_pc !== 16 || if_instr !== 32'h104) begin
      fails++;
      $display("FAIL fetch_reen: valid=%b pc=%h instr=%h, want 1/10/104", if_valid, if_pc, if_instr);
    end
  endtask
  task automatic test_async_reset_wrap();
    do_reset();
    step(2);
    id_ready = 1'b0;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (if_valid !== 1'b0 || im_addr !== 0 || fetch_cnt !== 0 || if_instr !== NOP || if_pc !== 0) begin
      fails++;
      $display("FAIL async_reset: valid=%b imaddr=%h cnt=%0d instr=%h pc=%h, want 0/0/0/13/0", if_valid, im_addr, fetch_cnt, if_instr, if_pc);
    end
    rst_n = 1'b1;
    m_valid = 0; m_instr = NOP; m_ifpc = 0; m_pc = 0; m_cnt = 0;
    @(negedge clk);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step(1);
    redirect = 1'b0;
    step(1);
    tests++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 0 || im_addr !== 0 || if_instr !== 32'h13F) begin
      fails++;
      $display("FAIL wrap_top: pc=%h pc4=%h imaddr=%h instr=%h, want fffffffc/0/0/13f", if_pc, if_pc4, im_addr, if_instr);
    end
    step(1);
    tests++;
    if (if_pc !== 0 || if_instr !== 32'h100) begin
      fails++;
      $display("FAIL wrap_next: pc=%h instr=%h, want 0/100", if_pc, if_instr);
    end
  endtask
  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fetch_en = ($urandom_range(0, 9) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 255);
      tick();
      tests++;
      if (if_valid !== m_valid || if_instr !== m_instr || (m_valid && if_pc !== m_ifpc) ||
          im_addr !== m_pc || fetch_cnt !== m_cnt || if_pc4 !== if_pc + 32'd4) begin
        fails++;
        errs++;
        if (errs < 10)
          $display("FAIL random c%0d: valid=%b instr=%h pc=%h imaddr=%h cnt=%0d, want %b/%h/%h/%h/%0d",
                   c, if_valid, if_instr, if_pc, im_addr, fetch_cnt, m_valid, m_instr, m_ifpc, m_pc, m_cnt);
      end
    end
    redirect = 1'b0;
  endtask
  initial begin
    fill_rom_seq();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_fetch_en();
    test_async_reset_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
